// File: rtl/bft_link_pkg.sv
// Shared constants, link state enum and saturating-add helper for the BFT leaf link.
package bft_link_pkg;

  localparam int PACKET_BITS_DEF = 49;
  localparam int VALID_BIT       = PACKET_BITS_DEF - 1;

  localparam int LEAF_LSB    = 43;
  localparam int LEAF_W      = 5;
  localparam int PORT_LSB    = 39;
  localparam int PORT_W      = 4;
  localparam int ADDR_LSB    = 32;
  localparam int ADDR_W      = 7;
  localparam int PAYLOAD_LSB = 0;
  localparam int PAYLOAD_W   = 32;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DECOUPLED,
    RELEASE
  } link_state_e;

  // Adds inc to a, clamping at the all-ones value of a bits-wide counter (bits <= 64).
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [1:0] inc,
                                          input int unsigned bits);
    logic [63:0] max_v;
    max_v = (bits >= 64) ? '1 : ((64'd1 << bits) - 64'd1);
    if ((max_v - a) < {62'd0, inc}) begin
      return max_v;
    end
    return a + {62'd0, inc};
  endfunction

endpackage

// File: rtl/bft_leaf_link_if.sv
// Packet buses and decouple handshake between BFT leaf port, link stage and leaf wrapper.
interface bft_leaf_link_if
  import bft_link_pkg::*;
#(
  parameter int PACKET_BITS = PACKET_BITS_DEF
);
  logic [PACKET_BITS-1:0] bft_din;
  logic [PACKET_BITS-1:0] leaf_din;
  logic [PACKET_BITS-1:0] leaf_dout;
  logic [PACKET_BITS-1:0] bft_dout;
  logic                   decouple;
  logic                   decouple_ack;
  logic                   leaf_reset;

  modport master (
    input  bft_din,
    input  leaf_dout,
    input  decouple,
    output leaf_din,
    output bft_dout,
    output decouple_ack,
    output leaf_reset
  );

  modport slave (
    output bft_din,
    output leaf_dout,
    output decouple,
    input  leaf_din,
    input  bft_dout,
    input  decouple_ack,
    input  leaf_reset
  );
endinterface

// File: rtl/bft_link_pipe.sv
// Masked delay line: valid flits pass when en=1, everything else becomes an all-zero flit.
// Latency STAGES cycles; no backpressure, one flit per cycle.
module bft_link_pipe #(
  parameter int WIDTH  = 49,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             ap_rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  output logic [WIDTH-1:0] dout,
  output logic             accept,
  output logic             drop
);

  logic [WIDTH-1:0] stage_q [STAGES];

  assign accept = din[WIDTH-1] & en;
  assign drop   = din[WIDTH-1] & ~en;

  // Idle flits are zeroed at entry so stale data bits never reach the far side.
  always_ff @(posedge clk) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= accept ? din : '0;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/bft_leaf_link.sv
// BFT leaf link: registered pipes both ways plus drain/isolate/release control for DFX.
// Latency PIPE_STAGES cycles per direction; no backpressure. LINK_STATS_EN enables counters.
module bft_leaf_link
  import bft_link_pkg::*;
#(
  parameter int PACKET_BITS    = PACKET_BITS_DEF,
  parameter int PIPE_STAGES    = 2,
  parameter int RELEASE_CYCLES = 16,
  parameter int CNT_BITS       = 32
) (
  input  logic                 clk,
  input  logic                 ap_rst_n,
  bft_leaf_link_if.master      lnk,
  output logic [CNT_BITS-1:0]  pkt_cnt_down,
  output logic [CNT_BITS-1:0]  pkt_cnt_up,
  output logic [CNT_BITS-1:0]  drop_cnt
);

  localparam int CW = $clog2(RELEASE_CYCLES + PIPE_STAGES + 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(PIPE_STAGES - 1);
  localparam logic [CW-1:0] REL_LOAD   = CW'(RELEASE_CYCLES - 1);

  link_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ack_q;
  logic          lrst_q;
  logic          run_en;
  logic          acc_down, acc_up, drop_down, drop_up;

  assign run_en = (state_q == RUN);

  bft_link_pipe #(.WIDTH(PACKET_BITS), .STAGES(PIPE_STAGES)) u_pipe_down (
    .clk      (clk),
    .ap_rst_n (ap_rst_n),
    .din      (lnk.bft_din),
    .en       (run_en),
    .dout     (lnk.leaf_din),
    .accept   (acc_down),
    .drop     (drop_down)
  );

  bft_link_pipe #(.WIDTH(PACKET_BITS), .STAGES(PIPE_STAGES)) u_pipe_up (
    .clk      (clk),
    .ap_rst_n (ap_rst_n),
    .din      (lnk.leaf_dout),
    .en       (run_en),
    .dout     (lnk.bft_dout),
    .accept   (acc_up),
    .drop     (drop_up)
  );

  // Handshake outputs are flopped from the next state so they carry no input-to-output path.
  always_ff @(posedge clk) begin
    if (!ap_rst_n) begin
      state_q <= RELEASE;
      cnt_q   <= REL_LOAD;
      ack_q   <= 1'b0;
      lrst_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= (state_d == DECOUPLED);
      lrst_q  <= (state_d == DECOUPLED) || (state_d == RELEASE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (lnk.decouple) begin
          state_d = DRAIN;
          cnt_d   = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        // A drain always runs to completion so both pipes are empty on isolation.
        if (cnt_q == '0) begin
          state_d = DECOUPLED;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DECOUPLED: begin
        if (!lnk.decouple) begin
          state_d = RELEASE;
          cnt_d   = REL_LOAD;
        end
      end
      RELEASE: begin
        if (lnk.decouple) begin
          state_d = DECOUPLED;
        end else if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = RELEASE;
        cnt_d   = REL_LOAD;
      end
    endcase
  end

  assign lnk.decouple_ack = ack_q;
  assign lnk.leaf_reset   = lrst_q;

`ifdef LINK_STATS_EN
  logic [CNT_BITS-1:0] down_q, up_q, drop_q;

  always_ff @(posedge clk) begin
    if (!ap_rst_n) begin
      down_q <= '0;
      up_q   <= '0;
      drop_q <= '0;
    end else begin
      if (acc_down) begin
        down_q <= CNT_BITS'(sat_add(64'(down_q), 2'd1, CNT_BITS));
      end
      if (acc_up) begin
        up_q <= CNT_BITS'(sat_add(64'(up_q), 2'd1, CNT_BITS));
      end
      drop_q <= CNT_BITS'(sat_add(64'(drop_q), {1'b0, drop_down} + {1'b0, drop_up}, CNT_BITS));
    end
  end

  assign pkt_cnt_down = down_q;
  assign pkt_cnt_up   = up_q;
  assign drop_cnt     = drop_q;
`else
  logic unused_stats;
  assign unused_stats = ^{acc_down, acc_up, drop_down, drop_up};

  assign pkt_cnt_down = '0;
  assign pkt_cnt_up   = '0;
  assign drop_cnt     = '0;
`endif

endmodule

// File: tb/tb_bft_leaf_link.sv
// Bench for bft_leaf_link: directed tables/sequences plus random traffic against a deadline-based model.
module tb_bft_leaf_link;
  import bft_link_pkg::*;

  localparam int PB = 49;
  localparam int PS = 2;
  localparam int RC = 16;
  localparam int CB = 32;
  localparam logic [PB-1:0] V = 49'h1_0000_0000_0000;

  logic clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 clk = ~clk;

  bft_leaf_link_if #(.PACKET_BITS(PB)) lnk ();
  bft_leaf_link_if #(.PACKET_BITS(PB)) lnk_s ();

  logic [CB-1:0] pkt_cnt_down, pkt_cnt_up, drop_cnt;
  logic [3:0]    s_down, s_up, s_drop;

  bft_leaf_link #(.PACKET_BITS(PB), .PIPE_STAGES(PS), .RELEASE_CYCLES(RC), .CNT_BITS(CB)) dut (
    .clk (clk), .ap_rst_n (ap_rst_n), .lnk (lnk),
    .pkt_cnt_down (pkt_cnt_down), .pkt_cnt_up (pkt_cnt_up), .drop_cnt (drop_cnt)
  );

  bft_leaf_link #(.PACKET_BITS(PB), .PIPE_STAGES(PS), .RELEASE_CYCLES(RC), .CNT_BITS(4)) dut_sat (
    .clk (clk), .ap_rst_n (ap_rst_n), .lnk (lnk_s),
    .pkt_cnt_down (s_down), .pkt_cnt_up (s_up), .drop_cnt (s_drop)
  );

  assign lnk_s.bft_din   = lnk.bft_din;
  assign lnk_s.leaf_dout = lnk.leaf_dout;
  assign lnk_s.decouple  = lnk.decouple;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic longint sat(longint v, int bits);
    longint m;
    m = (longint'(1) << bits) - 1;
    return (v > m) ? m : v;
  endfunction

  // Reference model: link is "open" only in run; phases end at absolute edge numbers.
  logic [PB-1:0] q_down[$], q_up[$];
  logic [PB-1:0] m_a, m_b;
  bit  m_run = 0, m_drain = 0, m_iso = 0, m_rel = 1;
  int  n = 0, drain_end = 0, rel_end = 0;
  longint c_down = 0, c_up = 0, c_drop = 0;

  always @(posedge clk) begin
    n++;
    if (!ap_rst_n) begin
      q_down = {};
      q_up = {};
      for (int i = 0; i < PS; i++) begin
        q_down.push_back('0);
        q_up.push_back('0);
      end
      m_run = 0; m_drain = 0; m_iso = 0; m_rel = 1;
      rel_end = n + RC;
      c_down = 0; c_up = 0; c_drop = 0;
    end else begin
      m_a = (lnk.bft_din[PB-1] && m_run) ? lnk.bft_din : '0;
      m_b = (lnk.leaf_dout[PB-1] && m_run) ? lnk.leaf_dout : '0;
      if (m_run) begin
        c_down += lnk.bft_din[PB-1];
        c_up   += lnk.leaf_dout[PB-1];
      end else begin
        c_drop += lnk.bft_din[PB-1] + lnk.leaf_dout[PB-1];
      end
      q_down.push_back(m_a); void'(q_down.pop_front());
      q_up.push_back(m_b);   void'(q_up.pop_front());
      if (m_run) begin
        if (lnk.decouple) begin m_run = 0; m_drain = 1; drain_end = n + PS; end
      end else if (m_drain) begin
        if (n == drain_end) begin m_drain = 0; m_iso = 1; end
      end else if (m_iso) begin
        if (!lnk.decouple) begin m_iso = 0; m_rel = 1; rel_end = n + RC; end
      end else if (m_rel) begin
        if (lnk.decouple) begin m_rel = 0; m_iso = 1; end
        else if (n == rel_end) begin m_rel = 0; m_run = 1; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("leaf_din", lnk.leaf_din, q_down[0]);
      chk("bft_dout", lnk.bft_dout, q_up[0]);
      chk("decouple_ack", lnk.decouple_ack, m_iso);
      chk("leaf_reset", lnk.leaf_reset, m_iso || m_rel);
      chk("sat_leaf_din", lnk_s.leaf_din, q_down[0]);
      chk("sat_leaf_reset", lnk_s.leaf_reset, m_iso || m_rel);
`ifdef LINK_STATS_EN
      chk("pkt_cnt_down", pkt_cnt_down, sat(c_down, CB));
      chk("pkt_cnt_up", pkt_cnt_up, sat(c_up, CB));
      chk("drop_cnt", drop_cnt, sat(c_drop, CB));
      chk("sat_down", s_down, sat(c_down, 4));
      chk("sat_up", s_up, sat(c_up, 4));
      chk("sat_drop", s_drop, sat(c_drop, 4));
`else
      chk("cnt_zero", {pkt_cnt_down, pkt_cnt_up}, 64'd0);
      chk("drop_zero", {drop_cnt, 16'd0, s_down, s_up, s_drop}, 64'd0);
`endif
    end
  end

  typedef struct {
    logic [PB-1:0] bft;
    logic [PB-1:0] leaf;
    logic          dec;
    logic [PB-1:0] e_ld;
    logic [PB-1:0] e_bd;
    logic          e_ack;
    logic          e_lr;
  } vec_t;

  vec_t tbl[12];

  task automatic drive(input logic [PB-1:0] b, input logic [PB-1:0] l, input logic d);
    lnk.bft_din   = b;
    lnk.leaf_dout = l;
    lnk.decouple  = d;
  endtask

  int hi;
  int rst_hold;
  logic dec_r;
  logic [CB-1:0] base;

  initial begin
    tbl[0]  = '{V | 49'h1, 49'h0_1234_5678_9ABC, 1'b0, '0,         '0,          1'b0, 1'b0};
    tbl[1]  = '{V | 49'h2, V | 49'h12,           1'b0, V | 49'h1,  '0,          1'b0, 1'b0};
    tbl[2]  = '{V | 49'h3, V | 49'h13,           1'b1, V | 49'h2,  V | 49'h12,  1'b0, 1'b0};
    tbl[3]  = '{V | 49'h4, V | 49'h14,           1'b1, V | 49'h3,  V | 49'h13,  1'b0, 1'b0};
    tbl[4]  = '{V | 49'h5, V | 49'h15,           1'b1, '0,         '0,          1'b1, 1'b1};
    tbl[5]  = '{V | 49'h6, V | 49'h16,           1'b0, '0,         '0,          1'b0, 1'b1};
    for (int i = 6; i < 10; i++) tbl[i] = '{'0, '0, 1'b0, '0, '0, 1'b0, 1'b1};
    for (int i = 10; i < 12; i++) tbl[i] = '{'0, '0, 1'b1, '0, '0, 1'b1, 1'b1};

    drive('0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    ap_rst_n = 1'b1;

    // leaf_reset must stay high for exactly RC cycles after reset release
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (lnk.leaf_reset) hi++;
      else break;
    end
    chk("reset_release_len", hi, RC);

    // back-to-back flits, no gaps, PS cycles of latency
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      drive((i <= 8) ? (V | 49'(i)) : '0, '0, 1'b0);
      @(negedge clk);
      if (i >= 3) chk($sformatf("b2b_flit%0d", i - 2), lnk.leaf_din, V | 49'(i - 2));
    end
    @(posedge clk); #1;
`ifdef LINK_STATS_EN
    chk("b2b_cnt_down", pkt_cnt_down, 8);
`else
    chk("b2b_cnt_down", pkt_cnt_down, 0);
`endif
    repeat (2) begin @(posedge clk); #1; end

    // decouple table: accept on decouple cycle, drain, isolate, release, re-decouple
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].bft, tbl[i].leaf, tbl[i].dec);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_leaf_din", i), lnk.leaf_din, tbl[i].e_ld);
      chk($sformatf("tbl%0d_bft_dout", i), lnk.bft_dout, tbl[i].e_bd);
      chk($sformatf("tbl%0d_ack", i), lnk.decouple_ack, tbl[i].e_ack);
      chk($sformatf("tbl%0d_leaf_reset", i), lnk.leaf_reset, tbl[i].e_lr);
    end

    // valid flits on both sides while isolated are all dropped
    base = drop_cnt;
    for (int k = 0; k < 5; k++) begin
      drive(V | 49'(k + 32), V | 49'(k + 64), 1'b1);
      @(posedge clk); #1;
      chk("iso_outputs", {15'd0, lnk.leaf_din} | {15'd0, lnk.bft_dout}, 64'd0);
    end
`ifdef LINK_STATS_EN
    chk("iso_drop_delta", drop_cnt - base, 10);
`else
    chk("iso_drop_delta", drop_cnt - base, 0);
`endif

    // release: leaf_reset falls RC+1 cycles after decouple falls
    drive('0, '0, 1'b0);
    hi = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (lnk.leaf_reset) hi++;
      else break;
    end
    chk("decouple_release_len", hi, RC + 1);

    @(posedge clk); #1;
    for (int k = 0; k < 12; k++) begin
      drive(V | 49'(k + 100), '0, 1'b0);
      @(posedge clk); #1;
    end
    drive('0, '0, 1'b0);
`ifdef LINK_STATS_EN
    chk("total_down", pkt_cnt_down, 23);
    chk("total_up", pkt_cnt_up, 2);
    chk("total_drop", drop_cnt, 16);
    chk("sat4_down_hold", s_down, 15);
    chk("sat4_drop_hold", s_drop, 15);
`else
    chk("total_down", pkt_cnt_down, 0);
    chk("sat4_down_hold", s_down, 0);
`endif

    // random traffic with occasional decouple toggles and resets
    rst_hold = 0;
    dec_r = 1'b0;
    for (int k = 0; k < 800; k++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 15) == 0) dec_r = ~dec_r;
      if (rst_hold == 0 && $urandom_range(0, 249) == 0) rst_hold = $urandom_range(1, 3);
      if (rst_hold > 0) rst_hold--;
      ap_rst_n = (rst_hold == 0);
      drive({1'($urandom_range(0, 1)), $urandom(), 16'($urandom())},
            {1'($urandom_range(0, 1)), $urandom(), 16'($urandom())}, dec_r);
    end
    @(posedge clk); #1;
    ap_rst_n = 1'b1;
    drive('0, '0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bft_leaf_link.md
# bft_leaf_link

Registered link stage between a BFT switch leaf port and a leaf wrapper. It carries 49-bit packets in both directions through a fixed-depth pipeline, which gives timing closure across the DFX pblock boundary. It also decouples the leaf during partial reconfiguration: the link drains in-flight packets, isolates both directions and holds the leaf in reset until release completes. It sits on `din_leaf_bft2interface` and `dout_leaf_interface2bft` of every reconfigurable leaf.

## Interface
Single clock domain. Reset is synchronous and active-low.

Parameters:
- PACKET_BITS, 49: packet width. The MSB is the valid bit. Fields are leaf[47:43], port[42:39], addr[38:32] and payload[31:0].
- PIPE_STAGES, 2: register stages per direction. Legal range is 1..4.
- RELEASE_CYCLES, 16: number of cycles the leaf is held in reset after decouple is released or after system reset. Must be ≥1.
- CNT_BITS, 32: width of the statistics counters.

Ports:
- clk  in  1  clock
- ap_rst_n  in  1  synchronous active-low reset
- bft_din  in  PACKET_BITS  packet from the BFT switch
- leaf_din  out  PACKET_BITS  packet to the leaf (`din_leaf_bft2interface`)
- leaf_dout  in  PACKET_BITS  packet from the leaf (`dout_leaf_interface2bft`)
- bft_dout  out  PACKET_BITS  packet to the BFT switch
- decouple  in  1  level request to isolate the leaf
- decouple_ack  out  1  high while the link is fully isolated
- leaf_reset  out  1  active-high reset to the leaf wrapper
- pkt_cnt_down  out  CNT_BITS  count of valid packets accepted BFT→leaf
- pkt_cnt_up  out  CNT_BITS  count of valid packets accepted leaf→BFT
- drop_cnt  out  CNT_BITS  count of valid packets discarded while isolated

## Operation
- **Packet pipelines.** Each direction is a PIPE_STAGES-deep register chain.
  - An input flit with MSB=1 is accepted only when the state is RUN. Otherwise it is replaced by an all-zero flit.
  - An idle flit (MSB=0) is driven as all zeros at the output; its data bits are never propagated.
  - There is no backpressure. Every accepted flit emerges exactly PIPE_STAGES cycles later, unmodified.
- **FSM states:** RUN, DRAIN, DECOUPLED, RELEASE. State is registered and input masking uses the registered state.
  - **RUN.** Both directions pass packets. When decouple=1 is sampled, go to DRAIN and load the counter with PIPE_STAGES-1. A packet arriving in that same cycle is still accepted.
  - **DRAIN.** Inputs are masked. The counter decrements each cycle. When it reaches 0, go to DECOUPLED; both pipelines are empty at that point. Deasserting decouple during DRAIN does not abort the drain.
  - **DECOUPLED.** decouple_ack=1 and leaf_reset=1; both outputs are idle. When decouple=0 is sampled, go to RELEASE and load the counter with RELEASE_CYCLES-1.
  - **RELEASE.** leaf_reset=1, decouple_ack=0, inputs masked. The counter decrements each cycle.
    - When it reaches 0, go to RUN.
    - If decouple=1 is sampled during RELEASE, go directly to DECOUPLED.
- **Reset.**
  - While ap_rst_n=0:
    - All pipeline registers clear.
    - The state becomes RELEASE, with the counter loaded to RELEASE_CYCLES-1.
    - All statistics counters clear.
  - Reset applied mid-operation discards in-flight flits without counting them.
- **Counters.** All counters saturate at all-ones and never wrap.
  - pkt_cnt_down and pkt_cnt_up increment on each accepted valid input flit.
  - drop_cnt adds 1 for each valid flit masked on either input. If both inputs are masked in the same cycle, it adds 2, and the sum saturates.

## Timing
- Latency is exactly PIPE_STAGES cycles in each direction, with throughput of 1 flit per cycle.
- Output values during and immediately after reset:
  - leaf_din = 0, bft_dout = 0, decouple_ack = 0, counters = 0.
  - leaf_reset = 1.
- After ap_rst_n rises, leaf_reset stays high for RELEASE_CYCLES cycles, then falls.
- From decouple rising in RUN to decouple_ack=1 takes PIPE_STAGES cycles. The last accepted flit leaves the link in the cycle before decouple_ack rises.
- From decouple falling in DECOUPLED: decouple_ack falls after 1 cycle, and leaf_reset falls after RELEASE_CYCLES+1 cycles.
- decouple_ack and leaf_reset are driven directly from registers, with no combinational path from any input.

## Configuration
- LINK_STATS_EN:
  - When defined: the three counters are implemented as described above.
  - When undefined: no counter logic exists, and pkt_cnt_down, pkt_cnt_up and drop_cnt are tied to 0. The port list is identical in both builds.

## Structure
- Package bft_link_pkg holds:
  - the PACKET_BITS default, VALID_BIT, and field offset/width constants;
  - the link state enum (RUN, DRAIN, DECOUPLED, RELEASE);
  - a saturating-add helper function.
- Sub-module bft_link_pipe implements the parameterised masked delay line (data, mask enable, accept strobe). It is instantiated twice, once per direction.
- The FSM and the counters live in bft_leaf_link.

## Test plan
- Reset release with PIPE_STAGES=2, RELEASE_CYCLES=16 → leaf_reset high for exactly 16 cycles after ap_rst_n rises; both outputs 0 throughout.
- Back-to-back flits 0x1_0000_0000_0001…0x1_0000_0000_0008 on bft_din while in RUN → identical flits on leaf_din 2 cycles later with no gaps; pkt_cnt_down=8.
- Decouple asserted in the same cycle as a valid flit on leaf_dout → that flit appears on bft_dout 2 cycles later; decouple_ack rises 2 cycles after decouple; later flits are dropped and drop_cnt increments.
- Valid flits on both inputs every cycle for 5 cycles while DECOUPLED → outputs stay 0; drop_cnt=10.
- Decouple re-asserted at cycle 5 of RELEASE → decouple_ack=1 on the next cycle; leaf_reset never deasserts.
- With CNT_BITS=4 and 20 flits passed → pkt_cnt_down holds at 15. With LINK_STATS_EN undefined → all counters read 0.
